// File: rtl/shim_trigger_log_pkg.sv
// Shared definitions for the trigger timestamp logger.
//   word_sel_e      : readout word-select state (low half / high half of an entry)
//   WORD_WIDTH      : width of one host readout word
//   DEFAULT_*       : default parameter values for the logger and its FIFO
package shim_trigger_log_pkg;

  typedef enum logic {
    WS_LOW  = 1'b0,
    WS_HIGH = 1'b1
  } word_sel_e;

  localparam int WORD_WIDTH             = 32;
  localparam int DEFAULT_TS_WIDTH       = 48;
  localparam int DEFAULT_FIFO_DEPTH     = 16;
  localparam int DEFAULT_DROP_CNT_WIDTH = 16;

endpackage : shim_trigger_log_pkg

// File: rtl/shim_ts_sync_fifo.sv
// Generic single-clock first-word-fall-through FIFO.
//   clk, rst    : clock and synchronous active-high reset
//   clear       : synchronous flush, same effect as rst
//   wr_en       : push wr_data (ignored while full)
//   rd_en       : pop the head entry (ignored while empty)
//   rd_data     : head entry, valid whenever empty is low
//   full, empty : occupancy flags
module shim_ts_sync_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             wr_ok;
  logic             rd_ok;

  assign wr_ok = wr_en & ~full;
  assign rd_ok = rd_en & ~empty;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  // NOTE: storage is not reset; an entry is only ever read after it was
  // written, so clearing the array would cost flops and buy nothing.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values of the others.
      mem[wr_ptr] <= wr_data;
    end
  end

  // Depth is a power of two, so pointers wrap naturally at their width.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule : shim_ts_sync_fifo

// File: rtl/shim_trigger_timestamp_logger.sv
// Timestamps trigger pulses against a free-running cycle counter, buffers
// them in a FIFO and streams each entry to the host as two 32-bit words
// (low word first). Also keeps trigger/drop statistics.
//   clk, rst         : clock and synchronous active-high reset
//   trigger_in       : each high cycle is one trigger
//   log_en           : gates capture and counting of triggers
//   clear            : synchronous flush of FIFO, counters and flags
//   data_word_rd_en  : pop one readout word
//   data_word        : current readout word (0 when empty)
//   data_buf_empty   : no entry available
//   data_buf_full    : FIFO fully occupied
//   trigger_count    : triggers seen while logging, wrapping
//   dropped_count    : triggers lost to a full FIFO, saturating
//   overflow         : sticky, a trigger was dropped
//   underflow        : sticky, a read was attempted while empty
module shim_trigger_timestamp_logger
  import shim_trigger_log_pkg::*;
#(
  parameter int TS_WIDTH       = DEFAULT_TS_WIDTH,
  parameter int FIFO_DEPTH     = DEFAULT_FIFO_DEPTH,
  parameter int DROP_CNT_WIDTH = DEFAULT_DROP_CNT_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      trigger_in,
  input  logic                      log_en,
  input  logic                      clear,
  input  logic                      data_word_rd_en,
  output logic [WORD_WIDTH-1:0]     data_word,
  output logic                      data_buf_empty,
  output logic                      data_buf_full,
  output logic [31:0]               trigger_count,
  output logic [DROP_CNT_WIDTH-1:0] dropped_count,
  output logic                      overflow,
  output logic                      underflow
);

  logic [TS_WIDTH-1:0] ts_counter;
  logic [TS_WIDTH-1:0] fifo_rd_data;
  logic                fifo_full;
  logic                fifo_empty;
  logic                capture;
  logic                fifo_wr;
  logic                pop;
  logic                fifo_rd;
  word_sel_e           ws_q;
  word_sel_e           ws_d;

  assign capture = trigger_in & log_en;
  // Full is the start-of-cycle flag, so a trigger arriving with the final
  // HIGH pop of a full FIFO is dropped rather than taking the freed slot.
  assign fifo_wr = capture & ~fifo_full;
  assign pop     = data_word_rd_en & ~fifo_empty;
  // The entry is only released once its high word has been consumed.
  assign fifo_rd = pop & (ws_q == WS_HIGH);

  shim_ts_sync_fifo #(
    .WIDTH (TS_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .wr_en   (fifo_wr),
    .wr_data (ts_counter),
    .rd_en   (fifo_rd),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign data_buf_empty = fifo_empty;
  assign data_buf_full  = fifo_full;

  always_ff @(posedge clk) begin
    if (rst || clear) ts_counter <= '0;
    else              ts_counter <= ts_counter + TS_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      trigger_count <= '0;
      dropped_count <= '0;
      overflow      <= 1'b0;
      underflow     <= 1'b0;
    end else begin
      if (capture) begin
        trigger_count <= trigger_count + 32'd1;
        if (fifo_full) begin
          overflow <= 1'b1;
          if (dropped_count != '1) dropped_count <= dropped_count + DROP_CNT_WIDTH'(1);
        end
      end
      if (data_word_rd_en && fifo_empty) underflow <= 1'b1;
    end
  end

  // Word-select state machine: LOW -> HIGH -> LOW, one step per pop.
  always_ff @(posedge clk) begin
    if (rst) ws_q <= WS_LOW;
    else     ws_q <= ws_d;
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned (which would infer a latch).
    ws_d = ws_q;
    if (clear)    ws_d = WS_LOW;
    else if (pop) ws_d = (ws_q == WS_LOW) ? WS_HIGH : WS_LOW;
  end

  always_comb begin
    data_word = '0;
    if (!fifo_empty) begin
      if (ws_q == WS_LOW) data_word = fifo_rd_data[WORD_WIDTH-1:0];
      else                data_word = WORD_WIDTH'(fifo_rd_data >> WORD_WIDTH);
    end
  end

endmodule : shim_trigger_timestamp_logger

// File: doc/shim_trigger_timestamp_logger.md
Name: shim_trigger_timestamp_logger

Overview:
- Downstream consumer of the trigger core's `trigger_out` pulse stream.
- Timestamps every trigger cycle against a free-running cycle counter and buffers the timestamps in an internal FIFO.
- Host software reads the FIFO back as a stream of 32-bit words (low word, then high word).
- Also keeps trigger and drop statistics, so software can check that the expected trigger count matches what the hardware saw.

Parameters:
- TS_WIDTH, 48: timestamp counter width. Legal range 33..64.
- FIFO_DEPTH, 16: number of timestamp entries. Must be a power of two, ≥2.
- DROP_CNT_WIDTH, 16: width of the saturating dropped-trigger counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high; the block uses this single clock.
- trigger_in  in  1  trigger pulse from the trigger core; every high cycle is one trigger.
- log_en  in  1  when low, triggers are neither logged nor counted.
- clear  in  1  synchronous clear: empties the FIFO, zeroes counters and flags, restarts the timestamp counter.
- data_word_rd_en  in  1  pops one 32-bit readout word.
- data_word  out  32  current readout word (first-word-fall-through).
- data_buf_empty  out  1  no entry available.
- data_buf_full  out  1  all FIFO_DEPTH entries occupied.
- trigger_count  out  32  triggers seen while log_en is high, including dropped ones; wraps.
- dropped_count  out  DROP_CNT_WIDTH  triggers lost to a full FIFO; saturates at all-ones.
- overflow  out  1  sticky: at least one trigger was dropped.
- underflow  out  1  sticky: data_word_rd_en was asserted while empty.

Behaviour:
- Reset (rst=1) and clear=1 have identical effect:
  - FIFO empty, word-select = LOW.
  - ts_counter, trigger_count and dropped_count = 0.
  - overflow = underflow = 0.
  - Outputs: data_buf_empty=1, data_buf_full=0, data_word=0.
  - rst has priority over everything. clear has priority over capture and read in the same cycle.
- ts_counter:
  - Increments by 1 every cycle and wraps from 2^TS_WIDTH−1 to 0.
  - The captured value is the ts_counter value in the cycle where trigger_in=1.
- Capture (trigger_in=1 and log_en=1):
  - trigger_count increments.
  - If the FIFO is not full at the start of the cycle, the entry is written and becomes visible (data_buf_empty=0) the next cycle. Latency is 1 cycle.
  - If the FIFO is full, the entry is dropped, overflow←1 and dropped_count increments (saturating).
  - Full is evaluated before any same-cycle pop, so a trigger coinciding with the final-word pop while full is dropped.
- Back-to-back triggers (trigger_in high on consecutive cycles) each produce a separate entry with consecutive timestamps.
- Readout state machine, word-select ∈ {LOW, HIGH}:
  - LOW: data_word = entry[31:0]. A pop moves to HIGH; the entry is kept.
  - HIGH: data_word = zero-extended entry[TS_WIDTH−1:32]. A pop frees the entry and returns to LOW.
- data_word is 0 whenever the FIFO is empty.
- data_word_rd_en while empty: no state change, underflow←1.
- Simultaneous write and read are both honoured when not full. Occupancy then stays unchanged if the read was the HIGH pop, otherwise it grows by 1.
- log_en low: trigger_in is ignored entirely. Readout continues normally.
- FIFO pointers wrap modulo FIFO_DEPTH. Occupancy uses a counter of log2(FIFO_DEPTH)+1 bits.

Decomposition:
- Package shim_trigger_log_pkg holds:
  - the word-select encoding (WS_LOW=1'b0, WS_HIGH=1'b1);
  - the readout word width constant (32);
  - the default depth and width constants.
- Sub-module shim_ts_sync_fifo: generic single-clock, first-word-fall-through FIFO with width and depth parameters and full/empty/write/read ports.
- The top level owns:
  - the timestamp counter;
  - the statistics counters and sticky flags;
  - the word-select state machine.

Test Plan:
- Reset, log_en=1, single pulse at ts=100 → next cycle empty=0; reads give 100, then 0; then empty=1 and trigger_count=1.
- Three consecutive trigger cycles at ts=10/11/12 → six reads give 10,0,11,0,12,0; no overflow.
- FIFO_DEPTH=16, 20 triggers with no reads → full=1, dropped_count=4, overflow=1, trigger_count=20; the 16 stored timestamps match the first 16 triggers.
- Force ts_counter near 2^48−1 (or wait), trigger at ts=2^32+5 → reads give 5, then 1. A later trigger after wrap shows a small timestamp.
- Read on empty → underflow=1; no other state changes; data_word=0.
- clear during a half-read entry (word-select=HIGH) → next cycle empty=1, all counters 0. A subsequent trigger reads back starting with its LOW word.
